conv_encoder_framer: RTL and testbench
======================================

# conv_encoder_framer

Rate-1/2, constraint-length-3 convolutional encoder with frame control, the transmit-side counterpart of the Viterbi decoder's add-compare-select trellis. It accepts a frame of FRAME_LEN data bits over a valid/ready handshake and emits one 2-bit codeword per bit. It then appends two zero tail bits so the trellis terminates in state 00. Codewords stream one per cycle to the channel/decoder path, with a last-codeword flag.

## Interface
- FRAME_LEN, 6, data bits per frame, range 1..(2^CNT_W - 1); default gives 8 codewords per frame including tail.
- CNT_W, 4, width of the data-bit counter.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  frame start pulse; honoured only in IDLE.
- i_bit  in  1  data bit.
- i_valid  in  1  i_bit valid.
- o_ready  out  1  encoder accepts i_bit this cycle; high only in DATA.
- o_code  out  2  codeword {c1, c0}.
- o_code_valid  out  1  o_code valid, one cycle per codeword.
- o_code_last  out  1  high with the final (second tail) codeword only.
- o_busy  out  1  high in DATA, TAIL1, TAIL2.
- o_state  out  2  current trellis state {s1, s0}.

## Operation
- Trellis state {s1, s0}: s1 is the newest past bit, s0 the older one. Next state = {b, s1}. This gives the decoder's transitions: 00→00/10, 01→00/10, 10→01/11, 11→01/11.
- Generators 7,5 (octal): c1 = b^s1^s0 (111), c0 = b^s0 (101).
- FSM states are IDLE, DATA, TAIL1, TAIL2.
- IDLE
  - On i_start: go to DATA, clear trellis state to 00, clear the counter.
  - Otherwise stay in IDLE; i_valid is ignored.
- DATA
  - o_ready = 1.
  - On acceptance (i_valid & o_ready): encode b = i_bit, update the trellis state, increment the counter.
  - The acceptance that brings the counter to FRAME_LEN moves the FSM to TAIL1.
  - With no i_valid, the FSM holds and emits nothing.
- TAIL1: encode b = 0 unconditionally, go to TAIL2.
- TAIL2: encode b = 0, assert o_code_last with this codeword, go to IDLE.
- Every encode loads o_code, pulses o_code_valid and updates o_state on the same edge.
- After TAIL2, o_state is always 00.
- i_start outside IDLE is ignored. There is no frame abort; only rst terminates a frame.
- There is no downstream backpressure: the sink must consume one codeword per cycle when valid.
- Counter arithmetic is unsigned CNT_W-bit. Compare against FRAME_LEN, never against a wrapped value.

## Timing
- Reset values:
  - FSM in IDLE, trellis state 00, counter 0.
  - o_code=00, o_code_valid=0, o_code_last=0, o_busy=0, o_ready=0, o_state=00.
- Reset asserted mid-frame clears everything immediately (asynchronously) to the reset values; the partial frame is lost.
- i_start sampled at edge t: o_ready and o_busy are high from t+1.
- Data latency: bit accepted at edge t gives o_code/o_code_valid high during cycle t+1 (registered output).
- Last data bit accepted at edge t:
  - o_ready is low from t+1.
  - Tail-1 codeword appears at t+2.
  - Tail-2 codeword appears at t+3, together with o_code_last.
  - o_busy is low from t+3 edge onward, i.e. o_busy and o_code_last overlap for zero cycles; IDLE is entered at t+3.
- o_code holds its last value when o_code_valid=0. o_code_valid and o_code_last are single-cycle pulses.
- i_start in the same cycle as the TAIL2→IDLE transition is ignored. A new i_start may be given from the first IDLE cycle.
- Back-to-back frames: minimum gap between last tail codeword and the next frame's first codeword is 2 cycles (start plus accept).

## Test plan
- Reset/idle: hold rst=0, then release with no i_start.
  - Required: all outputs at reset values.
  - Required: o_ready stays 0 even with i_valid=1.
- Frame of bits 1,0,1,1,0,0, continuous valid.
  - Required codes: 11,10,00,01,01,11, then tail 00,00.
  - Required: o_code_last only on the 8th code; o_state 00 at end.
- Frame 1,1,1,1,1,1.
  - Required codes: 11,01,10,10,10,10, then tail 01,11.
  - Required: o_state after data = 11, after tail = 00.
- Gapped input: same frame as test 2 with i_valid low for 3 cycles between bits 3 and 4.
  - Required: identical code sequence, no o_code_valid during the gap.
  - Required: each code exactly one cycle after its acceptance edge.
- Spurious controls: i_start pulsed during DATA and TAIL1, plus i_valid during TAIL.
  - Required: ignored; the frame completes normally with 8 codewords.
  - Then: a second frame started immediately produces correct codes from state 00.
- Mid-frame reset: assert rst after 3 accepted bits.
  - Required: outputs return to reset values immediately.
  - Then: a new frame 1,0,1,1,0,0 yields 11,10,00,01,01,11,00,00.

Source files
------------

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 K=3 convolutional encoder (generators 7,5) with frame control.
// Accepts FRAME_LEN data bits, then flushes two zero tail bits to state 00.
module conv_encoder_framer #(
  parameter int FRAME_LEN = 6,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_bit,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [1:0] o_code,
  output logic       o_code_valid,
  output logic       o_code_last,
  output logic       o_busy,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL1,
    TAIL2
  } st_t;

  st_t              st_q, st_d;
  logic [1:0]       tr_q, tr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;

  logic             enc;
  logic             b;
  logic [CNT_W:0]   cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      tr_q   <= 2'b00;
      cnt_q  <= '0;
      code_q <= 2'b00;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      tr_q   <= tr_d;
      cnt_q  <= cnt_d;
      code_q <= code_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  // Widened increment so the end-of-frame compare never sees a wrap.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  always_comb begin
    st_d   = st_q;
    tr_d   = tr_q;
    cnt_d  = cnt_q;
    code_d = code_q;
    vld_d  = 1'b0;
    last_d = 1'b0;
    enc    = 1'b0;
    b      = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (i_start) begin
          st_d  = DATA;
          tr_d  = 2'b00;
          cnt_d = '0;
        end
      end
      DATA: begin
        if (i_valid) begin
          enc   = 1'b1;
          b     = i_bit;
          cnt_d = cnt_inc[CNT_W-1:0];
          if (cnt_inc == (CNT_W+1)'(FRAME_LEN))
            st_d = TAIL1;
        end
      end
      TAIL1: begin
        enc  = 1'b1;
        st_d = TAIL2;
      end
      TAIL2: begin
        enc    = 1'b1;
        last_d = 1'b1;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (enc) begin
      code_d = {b ^ tr_q[1] ^ tr_q[0], b ^ tr_q[0]};
      tr_d   = {b, tr_q[1]};
      vld_d  = 1'b1;
    end
  end

  assign o_ready      = (st_q == DATA);
  assign o_busy       = (st_q != IDLE);
  assign o_code       = code_q;
  assign o_code_valid = vld_q;
  assign o_code_last  = last_q;
  assign o_state      = tr_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Randomized bench for conv_encoder_framer against a bit-stream model
// that derives each codeword from the window of the last three bits.
module tb_conv_encoder_framer;

  localparam int FL = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0;
  logic       i_bit = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [1:0] o_code;
  logic       o_code_valid;
  logic       o_code_last;
  logic       o_busy;
  logic [1:0] o_state;

  conv_encoder_framer #(.FRAME_LEN(FL), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_bit        (i_bit),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_code       (o_code),
    .o_code_valid (o_code_valid),
    .o_code_last  (o_code_last),
    .o_busy       (o_busy),
    .o_state      (o_state)
  );

  initial forever #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      npass++;
  endtask

  // Model: the frame is a bit stream (data then two zeros); the codeword for
  // bit k is a function of stream[k], stream[k-1], stream[k-2].
  bit         m_act = 1'b0;
  int         m_n = 0;
  bit         mq[$];
  logic [1:0] e_code = 2'b00;
  logic [1:0] e_state = 2'b00;
  bit         e_vld = 1'b0;
  bit         e_last = 1'b0;

  task automatic m_emit(input bit bb);
    int k;
    bit s1, s0;
    mq.push_back(bb);
    k  = mq.size() - 1;
    s1 = (k >= 1) ? mq[k-1] : 1'b0;
    s0 = (k >= 2) ? mq[k-2] : 1'b0;
    e_code  = {bb ^ s1 ^ s0, bb ^ s0};
    e_state = {bb, s1};
    e_vld   = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_act = 0; m_n = 0; mq.delete();
      e_code = 0; e_state = 0; e_vld = 0; e_last = 0;
    end else begin
      e_vld = 0; e_last = 0;
      if (!m_act) begin
        if (i_start) begin
          m_act = 1; m_n = 0; mq.delete(); e_state = 0;
        end
      end else if (m_n < FL) begin
        if (i_valid) begin
          m_emit(i_bit);
          m_n++;
        end
      end else begin
        m_emit(1'b0);
        if (mq.size() == FL + 2) begin
          e_last = 1; m_act = 0;
        end
      end
    end
  end

  logic [1:0] cap[$];

  initial forever begin
    @(negedge clk);
    if (o_code_valid) cap.push_back(o_code);
    chk("code_valid", 32'(o_code_valid), 32'(e_vld));
    chk("code", 32'(o_code), 32'(e_code));
    chk("code_last", 32'(o_code_last), 32'(e_last));
    chk("busy", 32'(o_busy), 32'(m_act));
    chk("ready", 32'(o_ready), 32'(m_act && m_n < FL));
    chk("state", 32'(o_state), 32'(e_state));
  end

  logic [1:0] st_data;

  // bits[i] is the i-th bit sent; gi/gl force a gap before bit gi.
  task automatic send_frame(input logic [FL-1:0] bits, input int gi,
                            input int gl, input bit spur, input bit rnd);
    cap.delete();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 0; i < FL; i++) begin
      int g;
      g = (i == gi) ? gl : (rnd ? int'($urandom_range(0, 2)) : 0);
      repeat (g) begin
        i_valid = 1'b0;
        i_bit   = 1'($urandom);
        i_start = spur;
        @(negedge clk);
      end
      i_valid = 1'b1;
      i_bit   = bits[i];
      i_start = spur;
      @(negedge clk);
    end
    st_data = o_state;
    i_valid = spur;
    i_start = spur;
    i_bit   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_start = 1'b0;
    i_bit   = 1'b0;
    #1;
  endtask

  function automatic logic [15:0] packed_cap();
    logic [15:0] v;
    v = '0;
    foreach (cap[i]) v = {v[13:0], cap[i]};
    return v;
  endfunction

  localparam logic [FL-1:0] F_A = 6'b001101;
  localparam logic [FL-1:0] F_B = 6'b111111;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_code", 32'(o_code), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_ready", 32'(o_ready), 0);
    #2 rst = 1'b1;
    @(negedge clk);
    i_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_ready", 32'(o_ready), 0);
    chk("idle_valid", 32'(o_code_valid), 0);
    i_valid = 1'b0;
    @(negedge clk); #1;

    send_frame(F_A, -1, 0, 0, 0);
    chk("fa_codes", 32'(packed_cap()), 32'h0000E170);
    chk("fa_count", cap.size(), 8);
    chk("fa_end_state", 32'(o_state), 0);

    send_frame(F_B, -1, 0, 0, 0);
    chk("fb_codes", 32'(packed_cap()), 32'h0000DAA7);
    chk("fb_data_state", 32'(st_data), 3);
    chk("fb_end_state", 32'(o_state), 0);

    @(negedge clk); #1;
    send_frame(F_A, 3, 3, 0, 0);
    chk("gap_codes", 32'(packed_cap()), 32'h0000E170);

    @(negedge clk); #1;
    send_frame(F_A, -1, 0, 1, 0);
    chk("spur_codes", 32'(packed_cap()), 32'h0000E170);
    chk("spur_count", cap.size(), 8);
    send_frame(F_B, -1, 0, 0, 0);
    chk("b2b_codes", 32'(packed_cap()), 32'h0000DAA7);

    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_bit   = F_A[i];
      @(negedge clk);
    end
    i_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(o_code_valid), 0);
    chk("mrst_busy", 32'(o_busy), 0);
    chk("mrst_ready", 32'(o_ready), 0);
    chk("mrst_state", 32'(o_state), 0);
    chk("mrst_code", 32'(o_code), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk); #1;
    send_frame(F_A, -1, 0, 0, 0);
    chk("mrst_codes", 32'(packed_cap()), 32'h0000E170);

    for (int r = 0; r < 16; r++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
      send_frame(FL'($urandom), -1, 0, 1'($urandom), 1);
      chk("rnd_count", cap.size(), 8);
      chk("rnd_end_state", 32'(o_state), 0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
